btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Sits between the four raw push-button pins and the watch state-machine button inputs.
- Synchronizes and debounces each button, then converts each press into a single-cycle event pulse.
- Serializes simultaneous events by fixed priority, with a guaranteed idle gap so the state machine's two-stage next-state/state registers settle between events.
- Provides optional auto-repeat on increment/decrement while time-set states are active.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a level change.
- REPEAT_DELAY, 64: cycles a held inc/dec must be held after acceptance before the first repeat.
- REPEAT_RATE, 16: cycles between successive repeats.
- MIN_GAP, 2: idle cycles forced after every issued pulse.
- CNT_W, 8: width of debounce/repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- btn_mode_raw  in  1  asynchronous raw mode button, active-high
- btn_time_set_raw  in  1  raw time-set button
- btn_increment_raw  in  1  raw increment button
- btn_decrement_raw  in  1  raw decrement button
- repeat_en  in  1  high while the state machine is in hour-set or minute-set; enables auto-repeat
- btn_mode  out  1  single-cycle mode event
- btn_time_set  out  1  single-cycle time-set event
- btn_increment  out  1  single-cycle increment event
- btn_decrement  out  1  single-cycle decrement event
- busy  out  1  high when any event is pending or the gap counter is nonzero

Behaviour:
- Reset (reset==0 at clk edge): clears all outputs, synchronizers, debounced levels, counters, pending flags and gap counter. A button held through reset is treated as a new press after debounce.
- Synchronizer: two flops per raw input. Debounce logic uses only the second-stage output.
- Debounce, per button:
  - The counter increments while the synchronized value differs from the debounced level.
  - The counter clears on any agreement.
  - On the edge where the mismatch has lasted DEBOUNCE_CYCLES cycles, the debounced level flips and the counter clears.
  - A 0->1 flip sets that button's pending flag. A 1->0 flip sets nothing.
- Issue stage:
  - When the gap counter is 0 and any flag is pending, exactly one output pulses for one cycle (registered).
  - Priority: time_set > mode > increment > decrement.
  - The issued flag clears; the gap counter loads MIN_GAP and decrements to 0. No pulse is issued while it is nonzero.
- Uncontended latency: a clean raw press stable from cycle 0 pulses in cycle DEBOUNCE_CYCLES+3.
- Pending flags are one deep. A new press on an already-pending button merges and is lost; no counting.
- A pending flag persists across release; the event is still issued.
- Auto-repeat (increment/decrement only):
  - Active while repeat_en==1 and exactly one of inc/dec is debounced high.
  - Repeat counter starts at acceptance. After REPEAT_DELAY cycles, sets pending, then sets it every REPEAT_RATE cycles.
  - Release, repeat_en==0, or both inc and dec held clears the repeat counter immediately; no further repeats.
- Mid-operation reset: drops all pending events; no pulse in the cycle after reset assertion.
- Outputs are never high in two consecutive cycles. At most one output is high per cycle.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: auto-repeat implemented as above.
- Undefined: repeat counters not built, repeat_en ignored, each accepted press yields exactly one event.

Decomposition:
- Shared package watch_pkg:
  - button index constants (BTN_TIME_SET=0, BTN_MODE=1, BTN_INC=2, BTN_DEC=3) defining priority order;
  - NUM_BTN=4;
  - default parameter constants.
- Sub-module btn_debounce: synchronizer, debounce counter, debounced level and rise pulse. Instantiated once per button.
- Issue/arbitration, gap and repeat logic stay in btn_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=4, MIN_GAP=2.
- Clean press: btn_mode_raw high from cycle 0 -> btn_mode high in cycle 7 only; busy high cycles 6-9. Release produces no pulse.
- Bounce: btn_increment_raw toggles every 2 cycles for 20 cycles, then stays high -> no pulse during bouncing; single btn_increment 7 cycles after it settles.
- Simultaneous: all four raw inputs rise in cycle 0 -> pulses in order time_set(7), mode(10), increment(13), decrement(16); never adjacent.
- Auto-repeat: repeat_en=1, hold decrement 40 cycles -> first pulse at 7, repeats at ~15,19,23,...; release stops repeats. Same hold with repeat_en=0 -> one pulse.
- Inc+dec both held with repeat_en=1 -> one pulse each, no repeats.
- Reset mid-operation: assert reset (0) one cycle after three presses become pending -> no further pulses, busy=0; held buttons re-press 7 cycles after reset release.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared constants for the watch button front end.
// Button indices double as the issue priority: a lower index wins arbitration.
`timescale 1ns/1ps
package watch_pkg;

  localparam int NUM_BTN = 4;

  // Priority order, highest first.
  localparam int BTN_TIME_SET = 0;
  localparam int BTN_MODE     = 1;
  localparam int BTN_INC      = 2;
  localparam int BTN_DEC      = 3;

  // Default tuning for a typical system clock.
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY    = 64;
  localparam int DEF_REPEAT_RATE     = 16;
  localparam int DEF_MIN_GAP         = 2;
  localparam int DEF_CNT_W           = 8;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // One-hot grant of the lowest-index (highest-priority) request, or zero.
  function automatic btn_vec_t pick_first(input btn_vec_t req);
    btn_vec_t g;
    g = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchronizer, stability counter and
// debounced level. 'rise' is high in the cycle whose closing edge raises the
// debounced level, so the issue stage can latch the event on that same edge.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             mismatch;
  logic             accept;

  // Mismatch run length decides when the synchronized value is trusted.
  always_comb begin
    mismatch   = sync_reg[1] ^ level_reg;
    accept     = mismatch && (cnt_reg == CNT_LAST);
    cnt_next   = '0;
    level_next = level_reg;
    if (accept) begin
      level_next = ~level_reg;
    end else if (mismatch) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Synchronizer, counter and debounced level registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
    end
  end

  assign level = level_reg;
  assign rise  = accept & ~level_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Raw push-buttons to single-cycle state-machine events.
// Each button is debounced, every accepted press becomes a pending event, and
// events are issued one at a time by fixed priority with an idle gap between
// them. Define BTN_AUTOREPEAT_EN to build auto-repeat for increment/decrement
// while repeat_en is high; without it repeat_en is ignored.
`timescale 1ns/1ps
module btn_conditioner
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int MIN_GAP         = DEF_MIN_GAP,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_mode_raw,
  input  logic btn_time_set_raw,
  input  logic btn_increment_raw,
  input  logic btn_decrement_raw,
  input  logic repeat_en,
  output logic btn_mode,
  output logic btn_time_set,
  output logic btn_increment,
  output logic btn_decrement,
  output logic busy
);

  // The gap counter covers the pulse cycle plus MIN_GAP idle cycles; the next
  // pulse may land in the cycle where it has just reached zero.
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(MIN_GAP + 1);
  localparam logic [CNT_W-1:0] GAP_ONE  = CNT_W'(1);

  btn_vec_t         raw_vec;
  btn_vec_t         level_vec;
  btn_vec_t         rise_vec;
  btn_vec_t         rpt_set_vec;
  btn_vec_t         pending_reg, pending_next;
  btn_vec_t         grant;
  btn_vec_t         out_reg;
  logic [CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             issue_ok;

  assign raw_vec[BTN_TIME_SET] = btn_time_set_raw;
  assign raw_vec[BTN_MODE]     = btn_mode_raw;
  assign raw_vec[BTN_INC]      = btn_increment_raw;
  assign raw_vec[BTN_DEC]      = btn_decrement_raw;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .rise  (rise_vec[gi])
      );
    end
  endgenerate

`ifdef BTN_AUTOREPEAT_EN
  logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             rpt_armed_reg, rpt_armed_next;
  logic             rpt_active;
  logic             rpt_fire;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  // Repeat only when exactly one of inc/dec is held; anything else restarts.
  assign rpt_active = repeat_en & (level_vec[BTN_INC] ^ level_vec[BTN_DEC]);

  // Initial delay, then a fixed rate, measured from the debounced acceptance.
  always_comb begin
    rpt_cnt_next   = '0;
    rpt_armed_next = 1'b0;
    rpt_fire       = 1'b0;
    if (rpt_active) begin
      if (!rpt_armed_reg && (rpt_cnt_reg == DELAY_LAST)) begin
        rpt_fire       = 1'b1;
        rpt_armed_next = 1'b1;
      end else if (rpt_armed_reg && (rpt_cnt_reg == RATE_LAST)) begin
        rpt_fire       = 1'b1;
        rpt_armed_next = 1'b1;
      end else begin
        rpt_cnt_next   = rpt_cnt_reg + 1'b1;
        rpt_armed_next = rpt_armed_reg;
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt_reg   <= '0;
      rpt_armed_reg <= 1'b0;
    end else begin
      rpt_cnt_reg   <= rpt_cnt_next;
      rpt_armed_reg <= rpt_armed_next;
    end
  end

  // A repeat tick re-requests whichever of inc/dec is the one being held.
  always_comb begin
    rpt_set_vec          = '0;
    rpt_set_vec[BTN_INC] = rpt_fire & level_vec[BTN_INC];
    rpt_set_vec[BTN_DEC] = rpt_fire & level_vec[BTN_DEC];
  end

  wire unused_levels = level_vec[BTN_TIME_SET] ^ level_vec[BTN_MODE];
`else
  assign rpt_set_vec = '0;

  wire unused_rpt = repeat_en ^ (^level_vec)
                    ^ (^CNT_W'(REPEAT_DELAY)) ^ (^CNT_W'(REPEAT_RATE));
`endif

  assign issue_ok = (gap_cnt_reg <= GAP_ONE);

  // Arbitration: highest-priority pending event, only outside the gap window.
  always_comb begin
    grant = '0;
    if (issue_ok) begin
      grant = pick_first(pending_reg);
    end
  end

  // New presses and repeat ticks merge into one-deep pending flags.
  always_comb begin
    pending_next = (pending_reg & ~grant) | rise_vec | rpt_set_vec;
  end

  // Gap counter reloads on every issue and drains to zero.
  always_comb begin
    gap_cnt_next = gap_cnt_reg;
    if (|grant) begin
      gap_cnt_next = GAP_LOAD;
    end else if (gap_cnt_reg != '0) begin
      gap_cnt_next = gap_cnt_reg - 1'b1;
    end
  end

  // Pending flags, gap counter and registered event pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_reg <= '0;
      gap_cnt_reg <= '0;
      out_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      gap_cnt_reg <= gap_cnt_next;
      out_reg     <= grant;
    end
  end

  assign btn_time_set  = out_reg[BTN_TIME_SET];
  assign btn_mode      = out_reg[BTN_MODE];
  assign btn_increment = out_reg[BTN_INC];
  assign btn_decrement = out_reg[BTN_DEC];
  assign busy          = (|pending_reg) | (gap_cnt_reg != '0);

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings.
// Pulses are logged as cycle*4 + button index (0 time_set, 1 mode, 2 inc,
// 3 dec), where cycle 0 is the first cycle after reset release.
`timescale 1ns/1ps
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RR  = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_mode_raw = 1'b0, btn_time_set_raw = 1'b0;
  logic btn_increment_raw = 1'b0, btn_decrement_raw = 1'b0;
  logic repeat_en = 1'b0;
  logic btn_mode, btn_time_set, btn_increment, btn_decrement, busy;

  int checks = 0;
  int errors = 0;
  int ev_q[$];
  int exp_q[$];
  int busy_log[128];
  int adj_viol;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .MIN_GAP         (GAP),
    .CNT_W           (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_mode_raw      (btn_mode_raw),
    .btn_time_set_raw  (btn_time_set_raw),
    .btn_increment_raw (btn_increment_raw),
    .btn_decrement_raw (btn_decrement_raw),
    .repeat_en         (repeat_en),
    .btn_mode          (btn_mode),
    .btn_time_set      (btn_time_set),
    .btn_increment     (btn_increment),
    .btn_decrement     (btn_decrement),
    .busy              (busy)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Input pattern of each scenario as a function of the cycle number.
  task automatic drive(input int scn, input int c);
    btn_time_set_raw  = 1'b0;
    btn_mode_raw      = 1'b0;
    btn_increment_raw = 1'b0;
    btn_decrement_raw = 1'b0;
    repeat_en         = 1'b0;
    reset             = 1'b1;
    case (scn)
      1: btn_mode_raw = (c < 20);
      2: btn_increment_raw = (c < 20) ? ((c / 2) % 2 == 0) : 1'b1;
      3: begin
        btn_time_set_raw  = (c < 30);
        btn_mode_raw      = (c < 30);
        btn_increment_raw = (c < 30);
        btn_decrement_raw = (c < 30);
      end
      4: begin btn_decrement_raw = (c < 40); repeat_en = 1'b1; end
      5: begin btn_decrement_raw = (c < 40); repeat_en = 1'b0; end
      6: begin
        btn_increment_raw = (c < 40);
        btn_decrement_raw = (c < 40);
        repeat_en         = 1'b1;
      end
      7: begin
        btn_time_set_raw  = 1'b1;
        btn_mode_raw      = 1'b1;
        btn_increment_raw = 1'b1;
        reset             = !(c == 7 || c == 8);
      end
      default: ;
    endcase
  endtask

  task automatic run_scn(input int scn, input int ncyc, input string name);
    int prev_n;
    int n;
    logic [3:0] o;
    reset = 1'b0;
    btn_time_set_raw  = 1'b0;
    btn_mode_raw      = 1'b0;
    btn_increment_raw = 1'b0;
    btn_decrement_raw = 1'b0;
    repeat_en         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val({name, " reset outs"},
              int'({btn_decrement, btn_increment, btn_mode, btn_time_set}), 0);
    check_val({name, " reset busy"}, int'(busy), 0);
    ev_q.delete();
    adj_viol = 0;
    prev_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      drive(scn, c);
      @(negedge clk);
      o = {btn_decrement, btn_increment, btn_mode, btn_time_set};
      n = $countones(o);
      if (n > 1 || (n > 0 && prev_n > 0)) adj_viol++;
      for (int i = 0; i < 4; i++) if (o[i]) ev_q.push_back(c * 4 + i);
      busy_log[c] = int'(busy);
      prev_n = n;
      @(posedge clk);
      #1;
    end
    check_val({name, " pulse count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      check_val($sformatf("%s pulse%0d (cyc*4+btn)", name, i), ev_q[i], exp_q[i]);
    check_val({name, " adjacent/overlap pulses"}, adj_viol, 0);
    $display("scenario %s: %0d pulses observed", name, ev_q.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clean press: mode at 7, busy over 6..9, release silent.
    exp_q = '{29};
    run_scn(1, 40, "clean");
    check_val("clean busy c5", busy_log[5], 0);
    check_val("clean busy c6", busy_log[6], 1);
    check_val("clean busy c7", busy_log[7], 1);
    check_val("clean busy c9", busy_log[9], 1);
    check_val("clean busy c10", busy_log[10], 0);

    // Bounce ends low at 19, stable high from 20: pulse at 27.
    exp_q = '{110};
    run_scn(2, 40, "bounce");

    // Simultaneous: time_set 7, mode 10, inc 13, dec 16.
    exp_q = '{28, 41, 54, 67};
    run_scn(3, 45, "simul");

    // Held decrement with repeat_en.
`ifdef BTN_AUTOREPEAT_EN
    exp_q = '{31};
    for (int k = 0; k < 9; k++) exp_q.push_back((15 + 4 * k) * 4 + 3);
`else
    exp_q = '{31};
`endif
    run_scn(4, 60, "repeat_on");

    // Same hold without repeat_en: one event.
    exp_q = '{31};
    run_scn(5, 60, "repeat_off");

    // Inc and dec held together: one each, no repeats.
    exp_q = '{30, 43};
    run_scn(6, 60, "inc_dec");

    // Reset at cycle 7-8: pending dropped, re-press after release.
    exp_q = '{28, 64, 77, 90};
    run_scn(7, 35, "mid_reset");
    check_val("mid_reset busy c8", busy_log[8], 0);
    check_val("mid_reset busy c9", busy_log[9], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
